// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the fetch sequencer and the next-PC mux.
// The pc_sel encodings here are the single source of truth for both.
package pc_seq_pkg;

    localparam int unsigned PC_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        HALTED
    } state_e;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PCSEL_SEQ = 2'b00;
    localparam pc_sel_t PCSEL_BR  = 2'b01;
    localparam pc_sel_t PCSEL_J   = 2'b10;
    localparam pc_sel_t PCSEL_JR  = 2'b11;

    // Illegal multi-flag decodes still resolve: jr > jump > taken branch.
    function automatic pc_sel_t pc_sel_decode(input logic is_jr, input logic is_jump,
                                              input logic is_branch, input logic taken);
        pc_sel_t sel;
        if (is_jr)                  sel = PCSEL_JR;
        else if (is_jump)           sel = PCSEL_J;
        else if (is_branch && taken) sel = PCSEL_BR;
        else                        sel = PCSEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/hs_timeout_ctr.sv
// Handshake watchdog: counts enabled cycles and flags the cycle in which the
// count would reach TIMEOUT.
module hs_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch controller: instruction-memory handshake, IR capture,
// next-PC source selection and one PC write per retired instruction.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             imem_valid,
    output logic             ir_we,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_jump,
    input  logic             is_jr,
    input  logic             is_halt,
    input  logic             stall,
    output logic [1:0]       pc_sel,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e           r_state;
    state_e           w_state_d;
    pc_sel_t          r_pc_sel;
    pc_sel_t          w_sel_dec;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_retired;
    logic             w_set_err;
    logic             w_expired;
    logic             w_tmo_en;
    logic             w_tmo_clr;

    assign w_tmo_en  = (r_state == REQ) || (r_state == WAIT);
    assign w_tmo_clr = (w_state_d != r_state);

    hs_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_hs_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmo_clr),
        .i_enable  (w_tmo_en),
        .o_expired (w_expired)
    );

    assign w_sel_dec = pc_sel_decode(is_jr, is_jump, is_branch, branch_taken);

    // A completed handshake takes precedence over a watchdog expiring in the same cycle.
    always_comb begin
        w_state_d = r_state;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_d = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    if (imem_valid) begin
                        ir_we     = 1'b1;
                        w_state_d = EXEC;
                    end else begin
                        w_state_d = WAIT;
                    end
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_state_d = HALTED;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    ir_we     = 1'b1;
                    w_state_d = EXEC;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_state_d = HALTED;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (is_halt) begin
                        w_state_d = HALTED;
                    end else begin
                        pc_we     = 1'b1;
                        w_state_d = REQ;
                    end
                end
            end
            HALTED: begin
                w_state_d = HALTED;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc_sel  <= PCSEL_SEQ;
            r_mem_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == EXEC) r_pc_sel <= w_sel_dec;
            if (w_set_err) r_mem_err <= 1'b1;
            if (pc_we) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // The mux needs the select in the same cycle as pc_we; the register holds it afterwards.
    assign pc_sel      = (r_state == EXEC) ? w_sel_dec : r_pc_sel;
    assign imem_req    = (r_state == REQ);
    assign busy        = (r_state != IDLE) && (r_state != HALTED);
    assign halted      = (r_state == HALTED);
    assign mem_err     = r_mem_err;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: stimulus queues expected PC writes,
// a negedge monitor pops and checks them as pc_we pulses appear.
module tb_pc_fetch_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_valid = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_jr = 1'b0;
    logic        is_halt = 1'b0;
    logic        stall = 1'b0;

    logic        imem_req, ir_we, pc_we, busy, halted, mem_err;
    logic [1:0]  pc_sel;
    logic [15:0] retired_cnt;

    logic        imem_req_4, ir_we_4, pc_we_4, busy_4, halted_4, mem_err_4;
    logic [1:0]  pc_sel_4;
    logic [3:0]  retired_cnt_4;

    pc_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .ir_we(ir_we),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump),
        .is_jr(is_jr), .is_halt(is_halt), .stall(stall), .pc_sel(pc_sel),
        .pc_we(pc_we), .busy(busy), .halted(halted), .mem_err(mem_err),
        .retired_cnt(retired_cnt)
    );

    pc_fetch_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req_4),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .ir_we(ir_we_4),
        .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump),
        .is_jr(is_jr), .is_halt(is_halt), .stall(stall), .pc_sel(pc_sel_4),
        .pc_we(pc_we_4), .busy(busy_4), .halted(halted_4), .mem_err(mem_err_4),
        .retired_cnt(retired_cnt_4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ir_seen = 0;
    int   exp_ir = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, imem_req, 0);
        chk({tag, "_ir_we"}, ir_we, 0);
        chk({tag, "_pc_we"}, pc_we, 0);
        chk({tag, "_pc_sel"}, pc_sel, PCSEL_SEQ);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_mem_err"}, mem_err, 0);
        chk({tag, "_retired"}, retired_cnt, 0);
        chk({tag, "_retired4"}, retired_cnt_4, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {start, imem_ready, imem_valid, is_branch, branch_taken} = '0;
        {is_jump, is_jr, is_halt, stall} = '0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk_reset_outputs("post_reset");
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_imem_req", imem_req, 1);
    endtask

    // Entered with the DUT in REQ; leaves it in REQ after the PC write.
    task automatic instr(input int rdly, input bit same, input bit br, input bit tk,
                         input bit j, input bit jr, input int stall_n, input logic [1:0] esel);
        imem_ready = 1'b0;
        repeat (rdly) tick();
        imem_ready = 1'b1;
        imem_valid = same;
        exp_ir++;
        if (same) begin
            #2 chk("ir_we_same_cycle", ir_we, 1);
        end
        tick();
        if (!same) begin
            imem_ready = 1'b0;
            imem_valid = 1'b1;
            #2 chk("ir_we_wait", ir_we, 1);
            tick();
        end
        imem_ready = 1'b0;
        imem_valid = 1'b0;
        is_branch = br;
        branch_taken = tk;
        is_jump = j;
        is_jr = jr;
        stall = (stall_n > 0);
        repeat (stall_n) tick();
        stall = 1'b0;
        sb.push_back({esel, exp_cnt[15:0]});
        exp_cnt++;
        tick();
        {is_branch, branch_taken, is_jump, is_jr} = '0;
        chk("pc_sel_hold", pc_sel, esel);
        chk("retired_after", retired_cnt, exp_cnt);
        chk("back_in_req", imem_req, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ir_we) ir_seen++;
                chk("ir_pc_overlap", ir_we & pc_we, 0);
                if (pc_we) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pc_we_queue", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("pc_sel_at_we", pc_sel, e.sel);
                        chk("retired_at_we", retired_cnt, e.cnt);
                        chk("retired4_at_we", retired_cnt_4, e.cnt[3:0]);
                    end
                end
            end
        end
    end

    initial begin : stim
        #1;
        chk_reset_outputs("initial");
        do_reset();

        // Basic sequential fetches, with and without a WAIT cycle.
        begin_run();
        instr(1, 0, 0, 0, 0, 0, 0, PCSEL_SEQ);
        repeat (3) instr(0, 0, 0, 0, 0, 0, 0, PCSEL_SEQ);
        chk("retired_4", retired_cnt, 4);

        // Next-PC source selection and priority.
        instr(0, 1, 1, 1, 0, 0, 0, PCSEL_BR);
        instr(0, 1, 1, 0, 0, 0, 0, PCSEL_SEQ);
        instr(2, 1, 0, 0, 1, 0, 0, PCSEL_J);
        instr(0, 1, 0, 0, 1, 1, 0, PCSEL_JR);
        instr(0, 0, 1, 1, 1, 1, 0, PCSEL_JR);
        instr(0, 1, 1, 1, 1, 0, 0, PCSEL_J);

        // Stall held 5 cycles in EXEC.
        instr(0, 1, 0, 0, 0, 0, 5, PCSEL_SEQ);
        chk("retired_after_stall", retired_cnt, 11);

        // Halt in EXEC.
        imem_ready = 1'b1;
        imem_valid = 1'b1;
        exp_ir++;
        tick();
        {imem_ready, imem_valid} = '0;
        is_halt = 1'b1;
        #2 chk("halt_no_pc_we", pc_we, 0);
        tick();
        is_halt = 1'b0;
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_no_err", mem_err, 0);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        chk("halt_start_ignored", halted, 1);
        chk("halt_req_low", imem_req, 0);
        chk("halt_retired", retired_cnt, 11);
        chk("sb_empty_1", sb.size(), 0);

        // Timeout in REQ.
        do_reset();
        begin_run();
        repeat (14) tick();
        chk("tmo_req_not_yet", mem_err, 0);
        chk("tmo_req_still_req", imem_req, 1);
        tick();
        chk("tmo_req_err", mem_err, 1);
        chk("tmo_req_halted", halted, 1);
        chk("tmo_req_req_low", imem_req, 0);
        chk("tmo_req_busy", busy, 0);
        imem_ready = 1'b1;
        start = 1'b1;
        repeat (4) tick();
        {imem_ready, start} = '0;
        chk("tmo_req_sticky", mem_err, 1);
        chk("tmo_req_stays_halted", halted, 1);

        // Timeout in WAIT.
        do_reset();
        begin_run();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("tmo_wait_req_low", imem_req, 0);
        chk("tmo_wait_busy", busy, 1);
        repeat (14) tick();
        chk("tmo_wait_not_yet", mem_err, 0);
        tick();
        chk("tmo_wait_err", mem_err, 1);
        chk("tmo_wait_halted", halted, 1);
        repeat (3) tick();
        chk("tmo_wait_sticky", mem_err, 1);

        // Asynchronous reset while in WAIT.
        do_reset();
        begin_run();
        instr(0, 1, 0, 0, 0, 0, 0, PCSEL_SEQ);
        instr(0, 1, 0, 0, 1, 0, 0, PCSEL_J);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("wait_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        imem_valid = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        imem_valid = 1'b0;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_retired", retired_cnt, 0);
        chk("ir_count_1", ir_seen, exp_ir);

        // Counter wrap on the CNT_W=4 instance.
        begin_run();
        repeat (16) instr(0, 1, 0, 0, 0, 0, 0, PCSEL_SEQ);
        chk("wrap_retired16", retired_cnt, 16);
        chk("wrap_retired4", retired_cnt_4, 0);
        chk("wrap_dut4_busy", busy_4, 1);

        tick();
        chk("sb_empty_end", sb.size(), 0);
        chk("ir_count_end", ir_seen, exp_ir);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
